// File: rtl/direction_ctrl.sv
// direction_ctrl
//   Input stage for the Tron game. Raw board switches are synchronized,
//   debounced, and decoded into per-player heading requests. Headings are
//   committed only on game-tick boundaries, reversals are refused, and ticks
//   are suppressed while the debounced pause switch is on.
//
// Ports
//   clk       in   1  system clock, all state on the rising edge
//   reset     in   1  synchronous active-high reset
//   switches  in  10  raw asynchronous switches
//                     [9:6] P1 up/right/down/left, [5] pause, [4] unused,
//                     [3:0] P2 up/right/down/left
//   dir_p1    out  2  P1 heading (00 up, 01 right, 10 down, 11 left)
//   dir_p2    out  2  P2 heading, same encoding
//   tick      out  1  single-cycle game-step pulse
//   paused    out  1  debounced pause state
module direction_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_CYCLES     = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] switches,
  output logic [1:0] dir_p1,
  output logic [1:0] dir_p2,
  output logic       tick,
  output logic       paused
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TK_W = $clog2(TICK_CYCLES);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  // Switch bit 4 carries no function; packing the nine used bits keeps every
  // downstream vector fully consumed.
  logic       unused_sw4;
  logic [8:0] used_sw;
  assign unused_sw4 = switches[4];
  assign used_sw    = {switches[9:5], switches[3:0]};

  // Packed layout: [8:5] P1 up/right/down/left, [4] pause, [3:0] P2.
  logic [8:0] sync1_q;
  logic [8:0] sync2_q;
  logic [8:0] acc_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= used_sw;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: the counter tracks how long the synchronized value has
  // disagreed with the accepted value. The accepted value flips on the edge
  // where the disagreement has lasted DEBOUNCE_CYCLES edges.
  for (genvar gi = 0; gi < 9; gi++) begin : g_db
    logic [DB_W-1:0] cnt_q;
    logic [DB_W-1:0] cnt_d;
    logic            acc_q;
    logic            acc_d;

    always_comb begin
      cnt_d = '0;
      acc_d = acc_q;
      if (sync2_q[gi] != acc_q) begin
        if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          acc_d = sync2_q[gi];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
        acc_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        acc_q <= acc_d;
      end
    end

    assign acc_vec[gi] = acc_q;
  end

  // One-hot decode of {up, right, down, left}; result is {valid, heading}.
  function automatic logic [2:0] decode_req(input logic [3:0] bits);
    case (bits)
      4'b1000: decode_req = {1'b1, DIR_UP};
      4'b0100: decode_req = {1'b1, DIR_RIGHT};
      4'b0010: decode_req = {1'b1, DIR_DOWN};
      4'b0001: decode_req = {1'b1, DIR_LEFT};
      default: decode_req = 3'b000;
    endcase
  endfunction

  logic [2:0] p1_req;
  logic [2:0] p2_req;
  logic       p1_legal;
  logic       p2_legal;

  logic [1:0]      dir_p1_q, dir_p1_d;
  logic [1:0]      dir_p2_q, dir_p2_d;
  logic [TK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic            tick_q, tick_d;
  logic            paused_q;

  assign paused_q = acc_vec[4];

  // A reversal is the current heading with bit 1 flipped.
  assign p1_req   = decode_req(acc_vec[8:5]);
  assign p2_req   = decode_req(acc_vec[3:0]);
  assign p1_legal = p1_req[2] && (p1_req[1:0] != (dir_p1_q ^ 2'b10));
  assign p2_legal = p2_req[2] && (p2_req[1:0] != (dir_p2_q ^ 2'b10));

  // Pause is taken from its registered value, so a pause accepted on the
  // wrap edge does not cancel that tick.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    tick_d     = 1'b0;
    dir_p1_d   = dir_p1_q;
    dir_p2_d   = dir_p2_q;
    if (!paused_q) begin
      if (tick_cnt_q == TK_W'(TICK_CYCLES - 1)) begin
        tick_cnt_d = '0;
        tick_d     = 1'b1;
        if (p1_legal) begin
          dir_p1_d = p1_req[1:0];
        end
        if (p2_legal) begin
          dir_p2_d = p2_req[1:0];
        end
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      dir_p1_q   <= DIR_RIGHT;
      dir_p2_q   <= DIR_LEFT;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      dir_p1_q   <= dir_p1_d;
      dir_p2_q   <= dir_p2_d;
    end
  end

  assign dir_p1 = dir_p1_q;
  assign dir_p2 = dir_p2_q;
  assign tick   = tick_q;
  assign paused = paused_q;

endmodule

// File: doc/direction_ctrl.md
# direction_ctrl

Input stage of the Tron game. It conditions the raw board switches into per-player heading registers and a periodic game tick that the game-logic/renderer samples. The block synchronizes and debounces every used switch, decodes one-hot direction requests, and rejects 180° reversals. It commits new headings only on game-tick boundaries and suppresses ticks while paused.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized cycles needed before a switch value is accepted (≥2).
- `TICK_CYCLES`, default 1000: clock cycles per game tick (≥3).
- `clk`  in  1: system clock; every register in the block is clocked on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `switches`  in  10: raw, asynchronous board switches.
  - [9] P1 up, [8] P1 right, [7] P1 down, [6] P1 left
  - [5] pause
  - [4] unused
  - [3] P2 up, [2] P2 right, [1] P2 down, [0] P2 left
- `dir_p1`  out  2: P1 heading. 00 up, 01 right, 10 down, 11 left.
- `dir_p2`  out  2: P2 heading, same encoding as `dir_p1`.
- `tick`  out  1: single-cycle game-step pulse.
- `paused`  out  1: debounced pause state.

## Operation
- **Synchronizer:** switches [9:5] and [3:0] each pass through a 2-flop synchronizer. Bit [4] is ignored.
- **Debounce, per bit:**
  - A counter increments while the synchronized value differs from the accepted value, and clears whenever they match.
  - When the count reaches `DEBOUNCE_CYCLES`, the accepted value takes the synchronized value and the counter clears.
  - Any glitch shorter than `DEBOUNCE_CYCLES` leaves the accepted value unchanged.
- **Request decode, per player, from accepted bits:**
  - Exactly one of the four bits set: request that direction.
  - Zero bits set, or two or more set: no request.
- **Legality:** a request is legal only if it is not the reverse of the current heading. The reverse is the heading with bit 1 flipped (`req == cur ^ 2'b10`).
  - A request equal to the current heading is a no-op.
- **Tick counter:** runs 0 .. `TICK_CYCLES`-1.
  - On the edge where count == `TICK_CYCLES`-1 and `paused` is 0, all of the following happen together:
    - count wraps to 0;
    - `tick` is registered to 1 for the next cycle;
    - each player with a legal request loads it into `dir_pN`.
  - On every other edge, `tick` is registered to 0.
  - While `paused` is 1, the count holds its value, `tick` stays 0 and the headings hold.
- **Player independence:** the two players are evaluated independently on the same tick. P1 and P2 may both change, or either may change alone.
- **Heading stability:** `dir_pN` never changes on a non-tick edge.

## Timing
- **Reset values**, applied at the first rising edge with `reset` high, and also when `reset` is asserted mid-operation:
  - `dir_p1` = 01 (right), `dir_p2` = 11 (left);
  - `tick` = 0, `paused` = 0;
  - tick count = 0;
  - synchronizer flops = 0, all accepted values = 0, debounce counters = 0.
- **During reset:** the switches are ignored.
- **Switch-to-accepted latency:** 2 cycles of synchronizer plus `DEBOUNCE_CYCLES` cycles.
- **Tick schedule:** number the cycles from 0, where cycle 0 is the first cycle after reset deasserts. With no pause, `tick` is high in cycles `TICK_CYCLES`, 2·`TICK_CYCLES`, and so on.
- **Heading vs tick:** the new heading is visible in the same cycle that `tick` is high, so consumers sample `dir_pN` when `tick` = 1.
- **Pause boundary:** if `paused` rises on the same edge where the count reaches `TICK_CYCLES`-1, the tick fires, because pause is evaluated from its registered value.
- **Resume:** after pause deasserts, counting resumes from the held count with no lost or extra tick.
- **Request and tick on the same edge:** a request accepted on the same edge as a tick is not seen by that tick; it takes effect on the next tick.

## Test plan
- **Reset defaults** (`DEBOUNCE_CYCLES`=4, `TICK_CYCLES`=10 for all scenarios):
  - Stimulus: hold `reset` 4 cycles with switches = 0, then release.
  - Required: `dir_p1` = 01, `dir_p2` = 11, `paused` = 0.
  - Required: `tick` high only in cycles 10, 20, 30; headings unchanged.
- **Legal turns:**
  - Stimulus: switches = 10'b1000000001 (P1 up, P2 left) held.
  - Required: at the first tick at least 6 cycles after application, `dir_p1` = 00 and `dir_p2` stays 11.
  - Stimulus: then switches = 10'b0000001000 (P2 up).
  - Required: `dir_p2` = 00 at the next qualifying tick.
- **Reversal rejection:**
  - Stimulus: from reset, switches = 10'b0001000100 (P1 left, P2 right).
  - Required: both headings hold (01, 11) across 3 ticks.
- **Glitch and multi-bit inputs:**
  - Stimulus: bit 9 high for 3 cycles, then low.
  - Required: no heading change.
  - Stimulus: bits 9 and 7 both high, held.
  - Required: `dir_p1` stays 01.
- **Pause:**
  - Stimulus: set switch[5] at count 4.
  - Required: `paused` rises 6 cycles later.
  - Required: `tick` stays 0 and the count holds for 50 cycles.
  - Stimulus: clear switch[5].
  - Required: `paused` falls 6 cycles later; the next tick occurs after the remaining count completes.
- **Mid-run reset:**
  - Stimulus: with `dir_p1` = 00, assert `reset` for 1 cycle at count 7.
  - Required: all outputs return to reset values.
  - Required: the next tick arrives 10 cycles after reset deasserts.
